// File: rtl/arb_pkg.sv
// Shared definitions for the table-memory arbiter.
//   ADDR_BUS / DATA_BUS : memory address and data bus widths
//   ZERO_WORD           : all-zero data word used for idle bus values
//   arb_state_t         : arbiter FSM states
//   ARB_IDX_W(n)        : width of an index selecting one of n requesters
package arb_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int ARB_IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   ptr        : index where the search starts (highest priority)
//   exclude_en : when set, requester 'exclude' is skipped
//   exclude    : index to skip
//   valid      : a winner was found
//   idx        : winner index (0 when no winner)
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = ARB_IDX_W(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               exclude_en,
  input  logic [IDX_W-1:0]   exclude,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Walk the ring backwards so the candidate closest to ptr is written last
  // and therefore wins.
  always_comb begin
    int pos;
    pos   = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (req[pos] && !(exclude_en && (exclude == IDX_W'(pos)))) begin
        valid = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one table-memory port among NUM_REQ engines.
// A grant is locked for as long as the winner holds ce (a burst); the
// winner's request is passed combinationally to memory and mem_ready_i is
// routed back only to the winner.
//   clk, rst            : clock, synchronous active-high reset
//   req_ce_i/we/addr/width/data_i : per-requester request signals
//   req_data_o          : memory read data broadcast to all requesters
//   req_ready_o         : per-requester ready (only the active winner)
//   mem_ce/we/addr/width/data_o, mem_data_i, mem_ready_i : memory port
//   grant_o             : one-hot current grant, zero when idle
//   timeout_o           : sticky, a grant has been held HOLD_LIMIT cycles
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int HOLD_LIMIT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_ce_i,
  input  logic [NUM_REQ-1:0]  req_we_i,
  input  logic [ADDR_BUS-1:0] req_addr_i  [NUM_REQ-1:0],
  input  logic [3:0]          req_width_i [NUM_REQ-1:0],
  input  logic [DATA_BUS-1:0] req_data_i  [NUM_REQ-1:0],
  output logic [DATA_BUS-1:0] req_data_o,
  output logic [NUM_REQ-1:0]  req_ready_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_BUS-1:0] mem_addr_o,
  output logic [3:0]          mem_width_o,
  output logic [DATA_BUS-1:0] mem_data_o,
  input  logic [DATA_BUS-1:0] mem_data_i,
  input  logic                mem_ready_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic                timeout_o
);

  localparam int IDX_W = ARB_IDX_W(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_LIMIT);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_ce;
  logic             active;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  assign owner_ce = req_ce_i[gnt_idx_q];
  assign active   = (state_q == ARB_GRANT) && owner_ce;

  // While granted, the picker only matters in the release cycle, where the
  // requester that just dropped ce must not immediately win again.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_ce_i),
    .ptr        (rr_ptr_q),
    .exclude_en (state_q == ARB_GRANT),
    .exclude    (gnt_idx_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_GRANT;
          gnt_idx_d  = pick_idx;
          rr_ptr_d   = ptr_after(pick_idx);
          hold_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (owner_ce) begin
          // Burst continues: never revoked, even after timeout.
          if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
          if (hold_cnt_d == HOLD_MAX) begin
            timeout_d = 1'b1;
          end
        end else if (pick_valid) begin
          gnt_idx_d  = pick_idx;
          rr_ptr_d   = ptr_after(pick_idx);
          hold_cnt_d = '0;
        end else begin
          state_d    = ARB_IDLE;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Passthrough is combinational so a requester that registers its next
  // address on ready never sees a stale or duplicated memory cycle.
  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = ZERO_WORD;
    if (state_q == ARB_GRANT) begin
      grant_o[gnt_idx_q] = 1'b1;
    end
    if (active) begin
      mem_ce_o               = 1'b1;
      mem_we_o               = req_we_i[gnt_idx_q];
      mem_addr_o             = req_addr_i[gnt_idx_q];
      mem_width_o            = req_width_i[gnt_idx_q];
      mem_data_o             = req_data_i[gnt_idx_q];
      req_ready_o[gnt_idx_q] = mem_ready_i;
    end
  end

  assign req_data_o = mem_data_i;
  assign timeout_o  = timeout_q;

endmodule
